// File: rtl/display_arbiter_if.sv
// Display bus shared between the clock's base sources, the two overlay
// requesters and the arbitrated seven-segment output.
interface display_arbiter_if;
  logic [3:0]  mode;
  logic [63:0] base_seg;
  logic [63:0] base_chs;
  logic [1:0]  req;
  logic [15:0] ovl_seg;
  logic [15:0] ovl_chs;
  logic        dismiss;
  logic [7:0]  oout;
  logic [7:0]  chs;
  logic [1:0]  grant;

  modport master (
    output mode, base_seg, base_chs, req, ovl_seg, ovl_chs, dismiss,
    input  oout, chs, grant
  );

  modport slave (
    input  mode, base_seg, base_chs, req, ovl_seg, ovl_chs, dismiss,
    output oout, chs, grant
  );
endinterface

// File: rtl/display_arbiter.sv
// Arbitrates the 8-digit display between the mode-selected base source and the
// alarm / countdown overlays, with a dark gap on every switch and a minimum hold.
module display_arbiter #(
  parameter int BLANK_CYCLES = 1000,
  parameter int HOLD_CYCLES  = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  display_arbiter_if.slave bus
);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_BASE,
    ST_BLANK,
    ST_OVL
  } state_t;

  state_t        state_reg;
  logic [3:0]    mode_q_reg;
  logic          tgt_ovl_reg;
  logic          tgt_idx_reg;
  logic [1:0]    supp_reg;
  logic [BW-1:0] blank_cnt_reg;
  logic [HW-1:0] hold_cnt_reg;
  logic [7:0]    oout_reg;
  logic [7:0]    chs_reg;
  logic [1:0]    grant_reg;

  logic [7:0] base_seg_arr [8];
  logic [7:0] base_chs_arr [8];
  logic [7:0] ovl_seg_arr  [2];
  logic [7:0] ovl_chs_arr  [2];

  logic [1:0] elig;
  logic [1:0] supp_set;
  logic [1:0] supp_next;
  logic       hold_done;
  logic       blank_done;
  logic       other_idx;
  logic       preempt;
  logic       release_go;
  logic       retarget;
  logic       retarget_idx;
  logic [7:0] oout_next;
  logic [7:0] chs_next;

  for (genvar gi = 0; gi < 8; gi++) begin : g_base
    assign base_seg_arr[gi] = bus.base_seg[8*gi +: 8];
    assign base_chs_arr[gi] = bus.base_chs[8*gi +: 8];
  end

  // A dismissed requester stays suppressed until it drops its request once.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ovl
    assign ovl_seg_arr[gi] = bus.ovl_seg[8*gi +: 8];
    assign ovl_chs_arr[gi] = bus.ovl_chs[8*gi +: 8];
    assign supp_next[gi]   = supp_set[gi] | (supp_reg[gi] & bus.req[gi]);
  end

  always_comb begin
    elig         = bus.req & ~supp_reg;
    hold_done    = (hold_cnt_reg == HOLD_MAX);
    blank_done   = (blank_cnt_reg == BLANK_LAST);
    other_idx    = ~tgt_idx_reg;
    preempt      = (state_reg == ST_OVL) && !tgt_idx_reg && elig[1];
    release_go   = (state_reg == ST_OVL) && !preempt && hold_done &&
                   (!bus.req[tgt_idx_reg] || bus.dismiss);
    supp_set     = 2'b00;
    if (release_go && bus.dismiss) begin
      supp_set[tgt_idx_reg] = 1'b1;
    end

    // Base ranks below overlay 0, which ranks below overlay 1.
    retarget     = 1'b0;
    retarget_idx = 1'b0;
    if (state_reg == ST_BLANK) begin
      if (elig[1] && !(tgt_ovl_reg && tgt_idx_reg)) begin
        retarget     = 1'b1;
        retarget_idx = 1'b1;
      end else if (elig[0] && !tgt_ovl_reg) begin
        retarget     = 1'b1;
        retarget_idx = 1'b0;
      end
    end

    oout_next = 8'h00;
    chs_next  = 8'h00;
    case (state_reg)
      ST_BASE: begin
        if (!mode_q_reg[3]) begin
          oout_next = base_seg_arr[mode_q_reg[2:0]];
          chs_next  = base_chs_arr[mode_q_reg[2:0]];
        end
      end
      ST_OVL: begin
        oout_next = ovl_seg_arr[tgt_idx_reg];
        chs_next  = ovl_chs_arr[tgt_idx_reg];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_BASE;
      mode_q_reg    <= 4'd0;
      tgt_ovl_reg   <= 1'b0;
      tgt_idx_reg   <= 1'b0;
      supp_reg      <= 2'b00;
      blank_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
      oout_reg      <= 8'h00;
      chs_reg       <= 8'h00;
      grant_reg     <= 2'b00;
    end else begin
      supp_reg <= supp_next;
      oout_reg <= oout_next;
      chs_reg  <= chs_next;
      case (state_reg)
        ST_BASE: begin
          if (|elig) begin
            state_reg     <= ST_BLANK;
            tgt_ovl_reg   <= 1'b1;
            tgt_idx_reg   <= elig[1];
            blank_cnt_reg <= '0;
          end else if (bus.mode != mode_q_reg) begin
            state_reg     <= ST_BLANK;
            tgt_ovl_reg   <= 1'b0;
            blank_cnt_reg <= '0;
          end
        end
        ST_BLANK: begin
          if (retarget) begin
            tgt_ovl_reg   <= 1'b1;
            tgt_idx_reg   <= retarget_idx;
            blank_cnt_reg <= '0;
          end else if (blank_done) begin
            if (tgt_ovl_reg) begin
              state_reg    <= ST_OVL;
              grant_reg    <= tgt_idx_reg ? 2'b10 : 2'b01;
              hold_cnt_reg <= '0;
            end else begin
              state_reg  <= ST_BASE;
              mode_q_reg <= bus.mode;
            end
          end else begin
            blank_cnt_reg <= blank_cnt_reg + BW'(1);
          end
        end
        ST_OVL: begin
          if (preempt) begin
            state_reg     <= ST_BLANK;
            tgt_ovl_reg   <= 1'b1;
            tgt_idx_reg   <= 1'b1;
            grant_reg     <= 2'b00;
            blank_cnt_reg <= '0;
          end else if (release_go) begin
            state_reg     <= ST_BLANK;
            grant_reg     <= 2'b00;
            blank_cnt_reg <= '0;
            tgt_ovl_reg   <= elig[other_idx];
            tgt_idx_reg   <= other_idx;
          end else if (!hold_done) begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
          end
        end
        default: state_reg <= ST_BASE;
      endcase
    end
  end

  assign bus.oout  = oout_reg;
  assign bus.chs   = chs_reg;
  assign bus.grant = grant_reg;
endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed vector table, hand-checked corner
// sequences and random traffic, all compared against an owner/gap model.
module tb_display_arbiter;
  localparam int B = 4;
  localparam int H = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_arbiter_if bus();

  display_arbiter #(.BLANK_CYCLES(B), .HOLD_CYCLES(H)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model: who owns the display, or a dark gap heading toward a goal owner.
  bit         m_gap;
  int         m_owner;
  int         m_goal;
  int         m_left;
  int         m_held;
  int         m_base;
  bit [1:0]   m_supp;
  logic [7:0] m_oout;
  logic [7:0] m_chs;
  logic [1:0] m_grant;

  typedef struct {
    logic [3:0] mode;
    logic [1:0] req;
    logic [7:0] seg;
    logic [7:0] chs;
    logic [1:0] grant;
  } vec_t;
  vec_t vecs[$];

  task automatic model_reset();
    m_gap = 0; m_owner = -1; m_goal = -1; m_left = 0; m_held = 0;
    m_base = 0; m_supp = 2'b00; m_oout = 8'h00; m_chs = 8'h00; m_grant = 2'b00;
  endtask

  task automatic start_gap(int goal);
    m_gap = 1; m_goal = goal; m_left = B;
  endtask

  task automatic model_step();
    logic [1:0] el;
    logic [1:0] setm;
    int best;
    el = bus.req & ~m_supp;
    setm = 2'b00;
    best = el[1] ? 1 : (el[0] ? 0 : -1);
    m_oout = 8'h00;
    m_chs = 8'h00;
    if (!m_gap && m_owner < 0 && m_base < 8) begin
      m_oout = bus.base_seg[8*m_base +: 8];
      m_chs  = bus.base_chs[8*m_base +: 8];
    end else if (!m_gap && m_owner >= 0) begin
      m_oout = bus.ovl_seg[8*m_owner +: 8];
      m_chs  = bus.ovl_chs[8*m_owner +: 8];
    end
    if (m_gap) begin
      if (best > m_goal) start_gap(best);
      else begin
        m_left--;
        if (m_left == 0) begin
          m_gap = 0; m_owner = m_goal; m_held = 0;
          if (m_goal < 0) m_base = int'(bus.mode);
        end
      end
    end else if (m_owner < 0) begin
      if (best >= 0) start_gap(best);
      else if (int'(bus.mode) != m_base) start_gap(-1);
    end else if (m_owner == 0 && el[1]) begin
      start_gap(1);
    end else if (m_held >= H && (!bus.req[m_owner] || bus.dismiss)) begin
      if (bus.dismiss) setm[m_owner] = 1'b1;
      start_gap(el[1-m_owner] ? 1 - m_owner : -1);
    end else begin
      m_held++;
    end
    m_supp = setm | (m_supp & bus.req);
    m_grant = (!m_gap && m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(string name, logic [7:0] seg, logic [7:0] cs, logic [1:0] gr);
    check({name, "_oout"}, bus.oout, seg);
    check({name, "_chs"}, bus.chs, cs);
    check({name, "_grant"}, {6'b0, bus.grant}, {6'b0, gr});
    $display("check %s: oout=%h chs=%h grant=%b", name, bus.oout, bus.chs, bus.grant);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("model_oout", bus.oout, m_oout);
    check("model_chs", bus.chs, m_chs);
    check("model_grant", {6'b0, bus.grant}, {6'b0, m_grant});
  endtask

  task automatic set_in(logic [3:0] md, logic [1:0] rq, logic dis);
    bus.mode = md; bus.req = rq; bus.dismiss = dis;
  endtask

  function automatic void addv(int n, logic [3:0] md, logic [1:0] rq,
                               logic [7:0] sg, logic [7:0] cs, logic [1:0] gr);
    vec_t v;
    v.mode = md; v.req = rq; v.seg = sg; v.chs = cs; v.grant = gr;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  initial begin
    logic [1:0] prev_grant;
    for (int i = 0; i < 8; i++) begin
      bus.base_seg[8*i +: 8] = 8'hA0 | 8'(i);
      bus.base_chs[8*i +: 8] = 8'(1 << i);
    end
    bus.ovl_seg = {8'hC3, 8'h5A};
    bus.ovl_chs = {8'hF0, 8'h0F};
    set_in(4'd3, 2'b00, 1'b0);
    model_reset();

    // Reset, base switching, then a short overlay pulse.
    repeat (3) tick();
    chk_out("reset", 8'h00, 8'h00, 2'b00);
    rst_n = 1'b1;
    addv(1, 4'd3, 2'b00, 8'hA0, 8'h01, 2'b00);
    addv(4, 4'd3, 2'b00, 8'h00, 8'h00, 2'b00);
    addv(1, 4'd3, 2'b00, 8'hA3, 8'h08, 2'b00);
    addv(1, 4'd6, 2'b00, 8'hA3, 8'h08, 2'b00);
    addv(4, 4'd6, 2'b00, 8'h00, 8'h00, 2'b00);
    addv(1, 4'd6, 2'b00, 8'hA6, 8'h40, 2'b00);
    addv(1, 4'd9, 2'b00, 8'hA6, 8'h40, 2'b00);
    addv(6, 4'd9, 2'b00, 8'h00, 8'h00, 2'b00);
    addv(2, 4'd9, 2'b01, 8'h00, 8'h00, 2'b00);
    addv(2, 4'd2, 2'b00, 8'h00, 8'h00, 2'b00);
    addv(1, 4'd2, 2'b00, 8'h00, 8'h00, 2'b01);
    addv(10, 4'd2, 2'b00, 8'h5A, 8'h0F, 2'b01);
    addv(1, 4'd2, 2'b00, 8'h5A, 8'h0F, 2'b00);
    addv(4, 4'd2, 2'b00, 8'h00, 8'h00, 2'b00);
    addv(1, 4'd2, 2'b00, 8'hA2, 8'h04, 2'b00);
    foreach (vecs[i]) begin
      set_in(vecs[i].mode, vecs[i].req, 1'b0);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].seg, vecs[i].chs, vecs[i].grant);
    end

    // Preemption of countdown by alarm, then fall back to countdown.
    set_in(4'd2, 2'b01, 1'b0);
    tick();
    repeat (B) tick();
    chk_out("ovl0_entry", 8'h00, 8'h00, 2'b01);
    repeat (3) tick();
    chk_out("ovl0_shown", 8'h5A, 8'h0F, 2'b01);
    set_in(4'd2, 2'b11, 1'b0);
    tick();
    chk_out("preempt_blank", 8'h5A, 8'h0F, 2'b00);
    repeat (B) tick();
    chk_out("preempt_grant", 8'h00, 8'h00, 2'b10);
    tick();
    chk_out("alarm_shown", 8'hC3, 8'hF0, 2'b10);
    repeat (H) tick();
    set_in(4'd2, 2'b01, 1'b0);
    tick();
    chk_out("alarm_release", 8'hC3, 8'hF0, 2'b00);
    repeat (B) tick();
    chk_out("regrant_ovl0", 8'h00, 8'h00, 2'b01);
    set_in(4'd2, 2'b00, 1'b0);
    repeat (H + B + 2) tick();
    chk_out("back_base1", 8'hA2, 8'h04, 2'b00);

    // Dismiss: early pulse ignored, at expiry releases and suppresses.
    set_in(4'd2, 2'b10, 1'b0);
    tick();
    repeat (B) tick();
    repeat (5) tick();
    bus.dismiss = 1'b1;
    tick();
    chk_out("early_dismiss", 8'hC3, 8'hF0, 2'b10);
    bus.dismiss = 1'b0;
    repeat (4) tick();
    bus.dismiss = 1'b1;
    tick();
    chk_out("dismiss_release", 8'hC3, 8'hF0, 2'b00);
    bus.dismiss = 1'b0;
    repeat (B + 6) tick();
    chk_out("no_regrant", 8'hA2, 8'h04, 2'b00);
    bus.req = 2'b00;
    tick();
    bus.req = 2'b10;
    tick();
    repeat (B) tick();
    chk_out("regrant_alarm", 8'h00, 8'h00, 2'b10);
    bus.req = 2'b00;
    repeat (H + B + 2) tick();
    chk_out("back_base2", 8'hA2, 8'h04, 2'b00);

    // Retarget during a mode-change blank.
    set_in(4'd5, 2'b00, 1'b0);
    repeat (3) tick();
    bus.req = 2'b10;
    tick();
    repeat (B - 1) tick();
    chk_out("retarget_dark", 8'h00, 8'h00, 2'b00);
    tick();
    chk_out("retarget_grant", 8'h00, 8'h00, 2'b10);
    tick();
    chk_out("retarget_shown", 8'hC3, 8'hF0, 2'b10);
    bus.req = 2'b00;
    repeat (H + B + 2) tick();
    chk_out("back_base5", 8'hA5, 8'h20, 2'b00);

    // Suppress countdown, grant alarm, then reset asynchronously mid-overlay.
    bus.req = 2'b01;
    tick();
    repeat (B) tick();
    repeat (H) tick();
    bus.dismiss = 1'b1;
    tick();
    chk_out("supp0_release", 8'h5A, 8'h0F, 2'b00);
    bus.dismiss = 1'b0;
    repeat (B + 2) tick();
    chk_out("supp0_held", 8'hA5, 8'h20, 2'b00);
    bus.req = 2'b11;
    tick();
    repeat (B + 2) tick();
    chk_out("alarm_before_rst", 8'hC3, 8'hF0, 2'b10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_out("async_reset", 8'h00, 8'h00, 2'b00);
    bus.req = 2'b01;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    repeat (B) tick();
    chk_out("supp_cleared", 8'h00, 8'h00, 2'b01);
    bus.req = 2'b00;
    repeat (H + B + 2) tick();

    // Random traffic with live scan data on every source.
    prev_grant = bus.grant;
    for (int c = 0; c < 3000; c++) begin
      bus.base_seg = {$urandom, $urandom};
      bus.base_chs = {$urandom, $urandom};
      bus.ovl_seg = 16'($urandom);
      bus.ovl_chs = 16'($urandom);
      if ($urandom_range(0, 39) == 0) bus.mode = 4'($urandom);
      if ($urandom_range(0, 29) == 0) bus.req[0] = ~bus.req[0];
      if ($urandom_range(0, 29) == 0) bus.req[1] = ~bus.req[1];
      bus.dismiss = ($urandom_range(0, 7) == 0);
      tick();
      if (bus.grant != prev_grant)
        $display("rand cycle %0d: grant %b -> %b (mode=%0d req=%b)",
                 cyc, prev_grant, bus.grant, bus.mode, bus.req);
      prev_grant = bus.grant;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
